signal_src_sched: RTL
=====================

// Module: signal_src_sched
// PURPOSE
//  Time-multiplexed source scan scheduler for the correlator input signal mux.
//  Steps the mux select code through a programmed list of source codes.
//  Each switch happens only on an accumulator epoch strobe, so no epoch mixes two sources.
//  After each switch, sel_valid is blanked for a settle window; the source is then held for a programmed number of epochs.
// PARAMETERS
//  LIST_LEN    8   number of list entries (power of 2); IDX_W = log2(LIST_LEN)
//  CNT_W       16  width of dwell epoch counter
//  SETTLE_CYC  2   cycles sel_valid stays low after a switch (mux register + downstream pipe), >=1
// PORTS
//  pclk          in   1       system clock
//  reset         in   1       synchronous, active-high reset
//  start         in   1       pulse: begin scan from entry 0
//  stop          in   1       pulse: abort scan, return to IDLE
//  list_wr       in   1       write strobe for source list
//  list_addr     in   IDX_W   list entry address
//  list_data     in   4       source code written to list_addr
//  list_last     in   IDX_W   index of last active entry (scan wraps after it)
//  dwell_epochs  in   CNT_W   epochs to dwell per entry (0 treated as 1)
//  epoch         in   1       accumulator epoch-boundary strobe, 1 cycle
//  input_reg     out  4       select code driven to the signal mux
//  sel_valid     out  1       1 = selected source settled, data usable
//  switch_pulse  out  1       1-cycle pulse on the cycle input_reg changes
//  cur_idx       out  IDX_W   list index currently applied
//  busy          out  1       1 in any state except IDLE
//  bad_code      out  1       sticky: an unassigned code was skipped; cleared by start or reset
// BEHAVIOUR
//  Reset: input_reg=4'b0000 (imitator), sel_valid=0, switch_pulse=0, cur_idx=0, busy=0, bad_code=0.
//  Reset: all list entries=4'b0000; state=IDLE.
//  Valid codes: 0000 0001 0010 0100 1000-1111. Invalid: 0011 0101 0110 0111.
//  list_last and dwell_epochs are latched at start; later changes are ignored until the next start.
//  list_wr is accepted in any state, 1-cycle write. A written entry is used when next read.
//  States:
//   IDLE   : busy=0, sel_valid=0, input_reg holds. On start: idx=0, bad_code=0 -> WAIT.
//   WAIT   : waits for epoch.
//            If list[idx] is invalid: bad_code=1, idx=wrap(idx+1), stay WAIT; 1 cycle per skip, epoch ignored that cycle.
//            If list[idx] is valid and epoch=1: switch (below) -> SETTLE.
//   SETTLE : sel_valid=0; counts SETTLE_CYC cycles after the switch edge, then -> DWELL with sel_valid=1.
//            Epochs seen during SETTLE are not counted.
//   DWELL  : sel_valid=1; counts epoch strobes. On the Nth epoch (N=max(dwell_epochs,1)), nidx=wrap(idx+1):
//            if list[nidx] is valid: switch to nidx on that same epoch -> SETTLE;
//            otherwise idx=nidx -> WAIT (the skip logic then runs).
//  Switch: on the clock edge after epoch is sampled, input_reg<=list[idx] and cur_idx<=idx.
//   switch_pulse=1 for that one cycle; sel_valid=0 from the same edge.
//   The switch occurs (and blanks) even when the new code equals the old one.
//  wrap(i): i==list_last ? 0 : i+1. list_last=0 gives a single-entry scan that re-switches every dwell.
//  stop: highest priority, any state -> IDLE at next edge. input_reg holds, sel_valid=0, cur_idx holds.
//  start while busy: ignored. start and stop in the same cycle: stop wins.
//  epoch and stop in the same cycle: no switch.
//  All-invalid list: stays in WAIT cycling the skips, input_reg unchanged, bad_code=1, busy=1.
//  Epoch counter saturates; it is cleared on entry to DWELL.
// TESTING
//  1 Reset: assert reset 3 cycles mid-DWELL -> input_reg=0000, sel_valid=0, busy=0, bad_code=0, list reads 0000.
//  2 Scan: list={0001,1000,1011}, list_last=2, dwell=2, SETTLE=2, epoch every 10 cycles
//    -> input_reg 0001,1000,1011,0001...; switch_pulse aligned 1 cycle after each switching epoch.
//    -> sel_valid low exactly 2 cycles per switch; 2 counted epochs per entry.
//  3 Invalid skip: list={0001,0101,0010}, list_last=2 -> 0101 never driven, bad_code=1 after first pass.
//    -> scan goes 0001->(WAIT)->0010 on the following epoch.
//  4 Dwell 0: dwell_epochs=0 -> behaves as 1; switch on the first counted epoch after settle.
//  5 Collisions: stop with epoch in DWELL -> IDLE, input_reg unchanged, no switch_pulse.
//    start+stop same cycle -> stays IDLE.
//  6 Live rewrite: while busy, write entry 1=1111 before it is reached -> 1111 applied.
//    Change list_last while busy -> ignored until the next start.

Source files
------------

// File: rtl/signal_src_sched.sv
// -----------------------------------------------------------------------------
// signal_src_sched
// Time-multiplexed source scan scheduler for the correlator input signal mux.
// Steps the mux select code through a programmed list of source codes. A new
// source is applied only on an accumulator epoch strobe, so no epoch mixes two
// sources. After every switch sel_valid is held low for SETTLE_CYC cycles, and
// then the source is held for a programmed number of epochs.
//
// Ports
//   pclk          clock
//   reset         synchronous, active-high reset
//   start         pulse: begin scan from entry 0 (ignored while busy)
//   stop          pulse: abort scan, return to IDLE (highest priority)
//   list_wr       source list write strobe (accepted in any state)
//   list_addr     source list write address
//   list_data     source code written to list_addr
//   list_last     index of last active entry, latched at start
//   dwell_epochs  epochs to dwell per entry, latched at start (0 acts as 1)
//   epoch         accumulator epoch-boundary strobe (1 cycle)
//   input_reg     select code driven to the signal mux
//   sel_valid     selected source has settled, data usable
//   switch_pulse  1-cycle pulse on the cycle input_reg is reloaded
//   cur_idx       list index currently applied to input_reg
//   busy          scheduler is not IDLE
//   bad_code      sticky: an unassigned code was skipped; cleared by start
// -----------------------------------------------------------------------------
module signal_src_sched #(
  parameter int LIST_LEN   = 8,
  parameter int CNT_W      = 16,
  parameter int SETTLE_CYC = 2,
  parameter int IDX_W      = $clog2(LIST_LEN)
) (
  input  logic             pclk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             list_wr,
  input  logic [IDX_W-1:0] list_addr,
  input  logic [3:0]       list_data,
  input  logic [IDX_W-1:0] list_last,
  input  logic [CNT_W-1:0] dwell_epochs,
  input  logic             epoch,
  output logic [3:0]       input_reg,
  output logic             sel_valid,
  output logic             switch_pulse,
  output logic [IDX_W-1:0] cur_idx,
  output logic             busy,
  output logic             bad_code
);

  // Settle counter only needs to reach SETTLE_CYC-1.
  localparam int SC_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SC_W-1:0] SETTLE_LAST = SC_W'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_WAIT   = 2'b01,
    ST_SETTLE = 2'b10,
    ST_DWELL  = 2'b11
  } state_t;

  // Codes 0011, 0101, 0110, 0111 are unassigned mux inputs.
  function automatic logic code_valid(input logic [3:0] code);
    logic ok;
    case (code)
      4'b0011, 4'b0101, 4'b0110, 4'b0111: ok = 1'b0;
      default:                            ok = 1'b1;
    endcase
    return ok;
  endfunction

  // Next list index, wrapping to 0 after the latched last entry.
  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] idx,
                                                input logic [IDX_W-1:0] last);
    logic [IDX_W-1:0] nxt;
    if (idx == last) begin
      nxt = {IDX_W{1'b0}};
    end else begin
      nxt = idx + IDX_W'(1);
    end
    return nxt;
  endfunction

  logic [3:0]       list_mem_r [LIST_LEN];

  state_t           state_r,        state_nx_s;
  logic [IDX_W-1:0] idx_r,          idx_nx_s;
  logic [IDX_W-1:0] last_r,         last_nx_s;
  logic [CNT_W-1:0] dwell_r,        dwell_nx_s;
  logic [CNT_W-1:0] epoch_cnt_r,    epoch_cnt_nx_s;
  logic [SC_W-1:0]  settle_cnt_r,   settle_cnt_nx_s;
  logic [3:0]       input_reg_r,    input_reg_nx_s;
  logic [IDX_W-1:0] cur_idx_r,      cur_idx_nx_s;
  logic             sel_valid_r,    sel_valid_nx_s;
  logic             switch_pulse_r, switch_pulse_nx_s;
  logic             busy_r;
  logic             bad_code_r,     bad_code_nx_s;

  logic [IDX_W-1:0] nidx_s;
  logic             sw_go_s;
  logic [IDX_W-1:0] sw_idx_s;
  logic             last_epoch_s;

  // Source list storage; a write is visible to the scheduler the next cycle.
  always_ff @(posedge pclk) begin
    if (reset) begin
      for (int i = 0; i < LIST_LEN; i++) begin
        list_mem_r[i] <= 4'b0000;
      end
    end else if (list_wr) begin
      list_mem_r[list_addr] <= list_data;
    end
  end

  // Next-state and next-output logic for the scan FSM.
  always_comb begin
    state_nx_s        = state_r;
    idx_nx_s          = idx_r;
    last_nx_s         = last_r;
    dwell_nx_s        = dwell_r;
    epoch_cnt_nx_s    = epoch_cnt_r;
    settle_cnt_nx_s   = settle_cnt_r;
    input_reg_nx_s    = input_reg_r;
    cur_idx_nx_s      = cur_idx_r;
    sel_valid_nx_s    = 1'b0;
    switch_pulse_nx_s = 1'b0;
    bad_code_nx_s     = bad_code_r;
    sw_go_s           = 1'b0;
    sw_idx_s          = idx_r;
    nidx_s            = wrap_idx(idx_r, last_r);
    // This epoch completes the dwell when (count so far + 1) reaches the target.
    last_epoch_s      = ({1'b0, epoch_cnt_r} + {{CNT_W{1'b0}}, 1'b1}) >= {1'b0, dwell_r};

    if (stop) begin
      // Abort wins over everything; select code and index are left as they are.
      state_nx_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            idx_nx_s      = {IDX_W{1'b0}};
            bad_code_nx_s = 1'b0;
            last_nx_s     = list_last;
            dwell_nx_s    = (dwell_epochs == {CNT_W{1'b0}}) ? CNT_W'(1) : dwell_epochs;
            state_nx_s    = ST_WAIT;
          end else begin
            state_nx_s = ST_IDLE;
          end
        end

        ST_WAIT: begin
          // An invalid entry is skipped in one cycle regardless of epoch.
          if (!code_valid(list_mem_r[idx_r])) begin
            bad_code_nx_s = 1'b1;
            idx_nx_s      = nidx_s;
          end else if (epoch) begin
            sw_go_s  = 1'b1;
            sw_idx_s = idx_r;
          end else begin
            state_nx_s = ST_WAIT;
          end
        end

        ST_SETTLE: begin
          if (settle_cnt_r == SETTLE_LAST) begin
            state_nx_s     = ST_DWELL;
            sel_valid_nx_s = 1'b1;
            epoch_cnt_nx_s = {CNT_W{1'b0}};
          end else begin
            settle_cnt_nx_s = settle_cnt_r + SC_W'(1);
          end
        end

        ST_DWELL: begin
          sel_valid_nx_s = 1'b1;
          if (epoch) begin
            if (last_epoch_s) begin
              if (code_valid(list_mem_r[nidx_s])) begin
                sw_go_s  = 1'b1;
                sw_idx_s = nidx_s;
              end else begin
                // Let WAIT run the skip logic from the invalid entry.
                idx_nx_s       = nidx_s;
                state_nx_s     = ST_WAIT;
                sel_valid_nx_s = 1'b0;
              end
            end else if (epoch_cnt_r != {CNT_W{1'b1}}) begin
              epoch_cnt_nx_s = epoch_cnt_r + CNT_W'(1);
            end else begin
              epoch_cnt_nx_s = epoch_cnt_r;
            end
          end else begin
            epoch_cnt_nx_s = epoch_cnt_r;
          end
        end

        default: begin
          state_nx_s = ST_IDLE;
        end
      endcase

      // A switch reloads the mux even if the code is unchanged, and blanks.
      if (sw_go_s) begin
        input_reg_nx_s    = list_mem_r[sw_idx_s];
        cur_idx_nx_s      = sw_idx_s;
        idx_nx_s          = sw_idx_s;
        switch_pulse_nx_s = 1'b1;
        sel_valid_nx_s    = 1'b0;
        settle_cnt_nx_s   = {SC_W{1'b0}};
        state_nx_s        = ST_SETTLE;
      end else begin
        switch_pulse_nx_s = 1'b0;
      end
    end
  end

  // State and registered-output update.
  always_ff @(posedge pclk) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      idx_r          <= {IDX_W{1'b0}};
      last_r         <= {IDX_W{1'b0}};
      dwell_r        <= CNT_W'(1);
      epoch_cnt_r    <= {CNT_W{1'b0}};
      settle_cnt_r   <= {SC_W{1'b0}};
      input_reg_r    <= 4'b0000;
      cur_idx_r      <= {IDX_W{1'b0}};
      sel_valid_r    <= 1'b0;
      switch_pulse_r <= 1'b0;
      busy_r         <= 1'b0;
      bad_code_r     <= 1'b0;
    end else begin
      state_r        <= state_nx_s;
      idx_r          <= idx_nx_s;
      last_r         <= last_nx_s;
      dwell_r        <= dwell_nx_s;
      epoch_cnt_r    <= epoch_cnt_nx_s;
      settle_cnt_r   <= settle_cnt_nx_s;
      input_reg_r    <= input_reg_nx_s;
      cur_idx_r      <= cur_idx_nx_s;
      sel_valid_r    <= sel_valid_nx_s;
      switch_pulse_r <= switch_pulse_nx_s;
      busy_r         <= (state_nx_s != ST_IDLE);
      bad_code_r     <= bad_code_nx_s;
    end
  end

  assign input_reg    = input_reg_r;
  assign sel_valid    = sel_valid_r;
  assign switch_pulse = switch_pulse_r;
  assign cur_idx      = cur_idx_r;
  assign busy         = busy_r;
  assign bad_code     = bad_code_r;

endmodule
